ccore_sync_sink: RTL and testbench

Clocked sink stage placed directly downstream of the last self-timed control core in a token pipeline. It accepts tokens over the four-phase request/acknowledge handshake (the core's SENDOUT drives this block's request; this block's acknowledge drives the core's ACKIN). It captures the bundled data word, buffers it in a small FIFO, and presents it to synchronous logic with a valid/ready interface. The acknowledge is withheld while the FIFO is full, so backpressure propagates into the self-timed ring without token loss.

---
 rtl/ccore_sync_sink.sv | 174 +++++++++++++++++
 tb/tb_ccore_sync_sink.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ccore_sync_sink.sv
// ccore_sync_sink
// Clocked sink behind the last self-timed control core of a token pipeline.
// The four-phase REQ_IN/ACK_OUT handshake is synchronized into CLK. Each
// token's bundled data word is written into a small show-ahead FIFO. The FIFO
// is drained through a DOUT_VALID/DOUT_READY interface. ACK_OUT is withheld
// while the FIFO is full, so backpressure stalls the upstream ring and no
// token is lost.
//
// Optional feature macro: CCORE_SINK_TOKCNT_EN
//   Defined   -> adds the TOKEN_CNT output, a 16-bit wrapping count of
//                accepted tokens.
//   Undefined -> no counter and no port; behaviour is otherwise identical.
module ccore_sync_sink #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   REQ_IN,
  input  logic [DATA_W-1:0]      DATA_IN,
  output logic                   ACK_OUT,
  output logic [DATA_W-1:0]      DOUT,
  output logic                   DOUT_VALID,
  input  logic                   DOUT_READY,
  output logic [$clog2(DEPTH):0] LEVEL
`ifdef CCORE_SINK_TOKCNT_EN
  ,
  output logic [15:0]            TOKEN_CNT
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACKED = 1'b1
  } state_t;

  // Request synchronizer; only this chain ever looks at REQ_IN.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;

  // Handshake state and registered acknowledge.
  state_t state_q;
  logic   ack_q;

  // FIFO storage and bookkeeping.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_d;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_d;

  logic fifo_full;
  logic fifo_empty;
  logic wr_en;
  logic pop;

  // Shift REQ_IN through the synchronizer chain; the last stage is req_s.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], REQ_IN};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Full/empty come from the registered level. A pop in the same cycle
  // cannot make room for a write; that write happens one cycle later.
  assign fifo_full  = (level_q == FULL_LVL);
  assign fifo_empty = (level_q == '0);

  // One write per token: only the IDLE->ACKED transition writes. The
  // return-to-zero phase (ACKED) never writes.
  assign wr_en = (state_q == ST_IDLE) && req_s && !fifo_full;

  // A pop needs a valid head, so a pop request while empty is ignored.
  assign pop = !fifo_empty && DOUT_READY;

  // Handshake FSM with a registered ACK_OUT.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wr_en) begin
            state_q <= ST_ACKED;
            ack_q   <= 1'b1;
          end
        end
        ST_ACKED: begin
          if (!req_s) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  // Next-state for the pointers (which wrap modulo DEPTH) and the level.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Capture DATA_IN on the write edge. The storage has no reset; the pointers
  // and level define which entries are valid.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= DATA_IN;
    end
  end

  // Show-ahead head: DOUT follows the read pointer combinationally.
  assign DOUT       = mem_q[rd_ptr_q];
  assign DOUT_VALID = !fifo_empty;
  assign LEVEL      = level_q;
  assign ACK_OUT    = ack_q;

`ifdef CCORE_SINK_TOKCNT_EN
  logic [15:0] tok_cnt_q;

  // Count accepted tokens (FIFO writes). Wraps naturally; pops do not affect it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tok_cnt_q <= 16'h0000;
    end else if (wr_en) begin
      tok_cnt_q <= tok_cnt_q + 16'h0001;
    end
  end

  assign TOKEN_CNT = tok_cnt_q;
`endif

endmodule

// File: tb/tb_ccore_sync_sink.sv
// Directed testbench for ccore_sync_sink (DATA_W=8, DEPTH=4, SYNC_STAGES=2).
// The TOKEN_CNT checks are active when CCORE_SINK_TOKCNT_EN is defined.
module tb_ccore_sync_sink;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ_IN = 1'b0;
  logic [7:0] DATA_IN = 8'h00;
  logic       ACK_OUT;
  logic [7:0] DOUT;
  logic       DOUT_VALID;
  logic       DOUT_READY = 1'b0;
  logic [2:0] LEVEL;
`ifdef CCORE_SINK_TOKCNT_EN
  logic [15:0] TOKEN_CNT;
`endif

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // Pop monitor; it records the head on each cycle that ends in a pop.
  logic       mon_en = 1'b0;
  logic [7:0] mon_log [0:31];
  int         mon_n = 0;

  ccore_sync_sink #(
    .DATA_W(8),
    .DEPTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .REQ_IN(REQ_IN),
    .DATA_IN(DATA_IN),
    .ACK_OUT(ACK_OUT),
    .DOUT(DOUT),
    .DOUT_VALID(DOUT_VALID),
    .DOUT_READY(DOUT_READY),
    .LEVEL(LEVEL)
`ifdef CCORE_SINK_TOKCNT_EN
    ,
    .TOKEN_CNT(TOKEN_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (mon_en && DOUT_VALID && DOUT_READY && mon_n < 32) begin
      mon_log[mon_n] <= DOUT;
      mon_n <= mon_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait (bounded) until ACK_OUT reaches lvl; edges = clock edges consumed.
  task automatic wait_ack(input logic lvl, input int budget, output int edges);
    edges = 0;
    while (ACK_OUT !== lvl && edges < budget) begin
      tick();
      edges++;
    end
  endtask

  // Full four-phase token with a checked acknowledge in each phase.
  task automatic send_token(input logic [7:0] d);
    int e;
    DATA_IN = d;
    REQ_IN  = 1'b1;
    wait_ack(1'b1, 12, e);
    check($sformatf("tok%02h_ack_rise", d), {31'b0, ACK_OUT}, 32'd1);
    REQ_IN = 1'b0;
    wait_ack(1'b0, 12, e);
    check($sformatf("tok%02h_ack_fall", d), {31'b0, ACK_OUT}, 32'd0);
  endtask

  initial begin
    int e;

    // ---- Reset ----
    tick();
    tick();
    RESET = 1'b0;
    tick();
    check("rst_ack", {31'b0, ACK_OUT}, 32'd0);
    check("rst_valid", {31'b0, DOUT_VALID}, 32'd0);
    check("rst_level", {29'b0, LEVEL}, 32'd0);
`ifdef CCORE_SINK_TOKCNT_EN
    check("rst_tokcnt", {16'b0, TOKEN_CNT}, 32'd0);
`endif

    // ---- Single token ----
    DATA_IN = 8'hA5;
    REQ_IN  = 1'b1;
    wait_ack(1'b1, 8, e);
    check("t1_ack_rise", {31'b0, ACK_OUT}, 32'd1);
    check("t1_rise_lat_3to4", {31'b0, (e >= 3 && e <= 4)}, 32'd1);
    REQ_IN = 1'b0;
    wait_ack(1'b0, 8, e);
    check("t1_ack_fall", {31'b0, ACK_OUT}, 32'd0);
    check("t1_fall_lat", e, 32'd3);
    check("t1_dout", {24'b0, DOUT}, 32'hA5);
    check("t1_valid", {31'b0, DOUT_VALID}, 32'd1);
    check("t1_level", {29'b0, LEVEL}, 32'd1);
`ifdef CCORE_SINK_TOKCNT_EN
    check("t1_tokcnt", {16'b0, TOKEN_CNT}, 32'd1);
`endif
    DOUT_READY = 1'b1;
    tick();
    DOUT_READY = 1'b0;
    check("t1_drain_level", {29'b0, LEVEL}, 32'd0);
    check("t1_drain_valid", {31'b0, DOUT_VALID}, 32'd0);

    // ---- Fill and backpressure ----
    for (int i = 1; i <= 4; i++) send_token(8'(i));
    check("t2_level_full", {29'b0, LEVEL}, 32'd4);
    DATA_IN = 8'h05;
    REQ_IN  = 1'b1;
    wait_ack(1'b1, 10, e);
    check("t2_5th_held", {31'b0, ACK_OUT}, 32'd0);
    check("t2_head_01", {24'b0, DOUT}, 32'h01);
    DOUT_READY = 1'b1;
    tick();
    DOUT_READY = 1'b0;
    check("t2_pop_level", {29'b0, LEVEL}, 32'd3);
    check("t2_pop_no_ack_yet", {31'b0, ACK_OUT}, 32'd0);
    wait_ack(1'b1, 4, e);
    check("t2_5th_ack", {31'b0, ACK_OUT}, 32'd1);
    check("t2_5th_ack_lat", e, 32'd1);
    check("t2_level_refill", {29'b0, LEVEL}, 32'd4);
    check("t2_head_02", {24'b0, DOUT}, 32'h02);
    REQ_IN = 1'b0;
    wait_ack(1'b0, 8, e);
    check("t2_5th_ack_fall", {31'b0, ACK_OUT}, 32'd0);
    DOUT_READY = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("t2_drain_%0d", i), {24'b0, DOUT}, 32'(i));
      tick();
    end
    DOUT_READY = 1'b0;
    check("t2_empty_level", {29'b0, LEVEL}, 32'd0);

    // ---- Ordering and wrap ----
    mon_en     = 1'b1;
    DOUT_READY = 1'b1;
    for (int i = 0; i < 10; i++) send_token(8'h10 + 8'(i));
    tick();
    mon_en     = 1'b0;
    DOUT_READY = 1'b0;
    tick();
    check("t3_pop_count", mon_n, 32'd10);
    for (int i = 0; i < 10; i++)
      check($sformatf("t3_order_%0d", i), {24'b0, mon_log[i]}, 32'h10 + 32'(i));
    check("t3_level", {29'b0, LEVEL}, 32'd0);

    // ---- Simultaneous push/pop ----
    send_token(8'h20);
    send_token(8'h21);
    check("t4_level2", {29'b0, LEVEL}, 32'd2);
    DATA_IN = 8'h22;
    REQ_IN  = 1'b1;
    tick();
    tick();
    check("t4_no_ack_before_write", {31'b0, ACK_OUT}, 32'd0);
    DOUT_READY = 1'b1;
    tick();
    DOUT_READY = 1'b0;
    check("t4_write_ack", {31'b0, ACK_OUT}, 32'd1);
    check("t4_level_same", {29'b0, LEVEL}, 32'd2);
    check("t4_head_21", {24'b0, DOUT}, 32'h21);
    REQ_IN = 1'b0;
    wait_ack(1'b0, 8, e);
    DOUT_READY = 1'b1;
    check("t4_drain_21", {24'b0, DOUT}, 32'h21);
    tick();
    check("t4_drain_22", {24'b0, DOUT}, 32'h22);
    tick();
    DOUT_READY = 1'b0;
    check("t4_level_empty", {29'b0, LEVEL}, 32'd0);
`ifdef CCORE_SINK_TOKCNT_EN
    check("t4_tokcnt", {16'b0, TOKEN_CNT}, 32'd19);
`endif

    // ---- Reset mid-handshake ----
    send_token(8'h30);
    send_token(8'h31);
    DATA_IN = 8'h32;
    REQ_IN  = 1'b1;
    wait_ack(1'b1, 8, e);
    check("t5_acked", {31'b0, ACK_OUT}, 32'd1);
    check("t5_level3", {29'b0, LEVEL}, 32'd3);
    RESET = 1'b1;
    #1;
    check("t5_async_ack", {31'b0, ACK_OUT}, 32'd0);
    check("t5_level0", {29'b0, LEVEL}, 32'd0);
    check("t5_valid0", {31'b0, DOUT_VALID}, 32'd0);
`ifdef CCORE_SINK_TOKCNT_EN
    check("t5_tokcnt0", {16'b0, TOKEN_CNT}, 32'd0);
`endif
    tick();
    tick();
    RESET = 1'b0;
    wait_ack(1'b1, 8, e);
    check("t5_new_ack", {31'b0, ACK_OUT}, 32'd1);
    check("t5_new_lat", {31'b0, (e >= 3 && e <= 4)}, 32'd1);
    check("t5_new_level", {29'b0, LEVEL}, 32'd1);
    check("t5_new_dout", {24'b0, DOUT}, 32'h32);
    REQ_IN = 1'b0;
    wait_ack(1'b0, 8, e);
    check("t5_new_ack_fall", {31'b0, ACK_OUT}, 32'd0);
    check("t5_single_write", {29'b0, LEVEL}, 32'd1);
`ifdef CCORE_SINK_TOKCNT_EN
    check("t5_tokcnt1", {16'b0, TOKEN_CNT}, 32'd1);
`endif
    DOUT_READY = 1'b1;
    tick();
    DOUT_READY = 1'b0;
    check("t5_drained", {29'b0, LEVEL}, 32'd0);

`ifdef CCORE_SINK_TOKCNT_EN
    // ---- Counter wrap ----
    force dut.tok_cnt_q = 16'hFFFF;
    #1;
    release dut.tok_cnt_q;
    #1;
    check("t6_preload", {16'b0, TOKEN_CNT}, 32'hFFFF);
    send_token(8'h40);
    check("t6_wrap", {16'b0, TOKEN_CNT}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
